// File: rtl/sweep_pkg.sv
// Shared definitions for the triangle-sweep sequencer.
//   state_t        : sequencer state encoding (IDLE / UP / DOWN)
//   DEF_*          : default parameter values for the sequencer and its dwell timer
package sweep_pkg;

    localparam int unsigned DEF_WIDTH   = 7;
    localparam int unsigned DEF_MAX_POS = 4;
    localparam int unsigned DEF_DWELL_W = 8;
    localparam int unsigned DEF_CYC_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter for the sweep sequencer.
//   clk, rs_n : clock, asynchronous active-low reset
//   load      : load load_val this cycle (wins over en)
//   load_val  : value loaded into the counter
//   en        : count down by one per cycle; saturates at zero
//   zero_c    : counter currently equals zero (decoded from the register)
module sweep_dwell_timer
    import sweep_pkg::*;
#(
    parameter int unsigned DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rs_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               zero_c
);

    logic [DWELL_W-1:0] cnt;

    // Saturating at zero keeps the timer quiet if the owner ever stops reloading it.
    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Triangle-sweep controller: drives pos 0 -> MAX_POS -> 0, holding each position
// for dwell+1 cycles, for n_cycles triangles (0 = continuous). Abortable at any time.
//   clk, rs_n  : clock, asynchronous active-low reset
//   start      : start request, honoured only in IDLE and only without abort
//   abort      : return to IDLE on the next edge from any state
//   dwell      : hold time per position minus 1 (latched at start)
//   n_cycles   : triangles to run, 0 = continuous (latched at start)
//   pos        : current position
//   dir_up     : 1 while ascending
//   step       : one-cycle strobe in the cycle pos shows a new value
//   at_top     : pos == MAX_POS (decoded from registered pos)
//   at_bottom  : pos == 0 (decoded from registered pos)
//   busy       : sweep in progress
//   done       : one-cycle pulse on normal completion
//   cycle_cnt  : completed triangles since start
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MAX_POS = DEF_MAX_POS,
    parameter int unsigned DWELL_W = DEF_DWELL_W,
    parameter int unsigned CYC_W   = DEF_CYC_W
) (
    input  logic               clk,
    input  logic               rs_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CYC_W-1:0]   n_cycles,
    output logic [WIDTH-1:0]   pos,
    output logic               dir_up,
    output logic               step,
    output logic               at_top,
    output logic               at_bottom,
    output logic               busy,
    output logic               done,
    output logic [CYC_W-1:0]   cycle_cnt
);

    localparam logic [WIDTH-1:0] TOP_POS = WIDTH'(MAX_POS);

    state_t             state;
    logic [DWELL_W-1:0] dwell_q;
    logic [CYC_W-1:0]   ncyc_q;

    logic               tmr_zero;
    logic               tmr_load;
    logic               tmr_en;
    logic [DWELL_W-1:0] tmr_val;

    logic               start_go;
    logic               step_go;
    logic [WIDTH-1:0]   pos_inc;
    logic [WIDTH-1:0]   pos_dec;
    logic [CYC_W-1:0]   cnt_inc;
    logic               last_cycle;

    // Abort has priority over everything, including a start in IDLE.
    assign start_go = (state == ST_IDLE) && start && !abort;
    assign step_go  = (state != ST_IDLE) && !abort && tmr_zero;

    // Timer: loaded with the live dwell on start, reloaded with the latched dwell
    // on every step, cleared on abort.
    assign tmr_load = abort || start_go || step_go;
    assign tmr_val  = abort ? '0 : (start_go ? dwell : dwell_q);
    assign tmr_en   = (state != ST_IDLE);

    assign pos_inc    = pos + WIDTH'(1);
    assign pos_dec    = pos - WIDTH'(1);
    assign cnt_inc    = cycle_cnt + CYC_W'(1);
    assign last_cycle = (ncyc_q != '0) && (cnt_inc == ncyc_q);

    assign at_top    = (pos == TOP_POS);
    assign at_bottom = (pos == '0);

    sweep_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rs_n     (rs_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero_c   (tmr_zero)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            state     <= ST_IDLE;
            pos       <= '0;
            dir_up    <= 1'b1;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            dwell_q   <= '0;
            ncyc_q    <= '0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                // cycle_cnt deliberately holds so software can see how far it got.
                state  <= ST_IDLE;
                pos    <= '0;
                dir_up <= 1'b1;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            dwell_q   <= dwell;
                            ncyc_q    <= n_cycles;
                            cycle_cnt <= '0;
                            dir_up    <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_UP;
                        end
                    end
                    ST_UP: begin
                        if (step_go) begin
                            pos  <= pos_inc;
                            step <= 1'b1;
                            if (pos_inc == TOP_POS) begin
                                dir_up <= 1'b0;
                                state  <= ST_DOWN;
                            end
                        end
                    end
                    ST_DOWN: begin
                        if (step_go) begin
                            pos  <= pos_dec;
                            step <= 1'b1;
                            if (pos_dec == '0) begin
                                cycle_cnt <= cnt_inc;
                                dir_up    <= 1'b1;
                                if (last_cycle) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= ST_IDLE;
                                end else begin
                                    state <= ST_UP;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        pos   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Triangle-sweep controller for the analyzer's position/channel index. On a start pulse it drives a position value up from 0 to `MAX_POS`, then back down to 0, holding each position for a programmable dwell time. It repeats for a programmed number of cycles or runs continuously, and reports progress to the capture logic. It sits between the control/register front-end and the acquisition datapath, replacing free-running counter enables with a sequenced, abortable sweep.

## Interface
- `WIDTH`, 7: width of `pos`.
- `MAX_POS`, 4: sweep top position; must satisfy 1 ≤ `MAX_POS` ≤ 2^`WIDTH`−1.
- `DWELL_W`, 8: width of `dwell`.
- `CYC_W`, 4: width of `n_cycles` and `cycle_cnt`.
---
- `clk`  in  1: single clock, all state on rising edge.
- `rs_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: start request; sampled only in IDLE.
- `abort`  in  1: stop request; sampled in any state.
- `dwell`  in  `DWELL_W`: hold time per position, in cycles, minus 1. Latched at start.
- `n_cycles`  in  `CYC_W`: number of full triangles to run; 0 = continuous. Latched at start.
- `pos`  out  `WIDTH`: current position.
- `dir_up`  out  1: 1 while ascending, 0 while descending.
- `step`  out  1: one-cycle strobe, high in the cycle `pos` shows a new value.
- `at_top`  out  1: `pos == MAX_POS`.
- `at_bottom`  out  1: `pos == 0`.
- `busy`  out  1: sweep in progress.
- `done`  out  1: one-cycle pulse on normal completion.
- `cycle_cnt`  out  `CYC_W`: completed triangles since start.

## Operation
- States: IDLE, UP, DOWN.
- **IDLE**
  - Holds `pos`=0, `dir_up`=1, `busy`=0.
  - `start`=1 and `abort`=0: latch `dwell` and `n_cycles`, load the dwell timer with `dwell`, clear `cycle_cnt`, go to UP.
- **Dwell timer**
  - In UP/DOWN it decrements each cycle.
  - When it equals 0, a step occurs and the timer reloads the latched dwell.
  - `dwell`=0 gives one step per cycle.
- **UP step**
  - `pos` ← `pos`+1.
  - If the new `pos` == `MAX_POS`: go to DOWN, `dir_up` ← 0.
- **DOWN step**
  - `pos` ← `pos`−1.
  - If the new `pos` == 0: `cycle_cnt` ← `cycle_cnt`+1.
  - If latched `n_cycles`≠0 and the incremented count == `n_cycles`: go to IDLE, pulse `done`.
  - Otherwise go to UP with `dir_up` ← 1.
- **Triangle length:** one triangle is 2·`MAX_POS` steps.
- **Continuous mode** (`n_cycles`=0): `cycle_cnt` wraps modulo 2^`CYC_W`; `done` never fires.
- **abort** (any state): next edge goes to IDLE.
  - `pos` ← 0, `dir_up` ← 1, dwell timer cleared.
  - `cycle_cnt` holds its value; `done` is not asserted.
- **start while busy:** ignored.
- **start and abort in the same cycle in IDLE:** abort wins; the block stays in IDLE.
- **Inputs after start:** changes to `dwell`/`n_cycles` mid-sweep have no effect until the next start.
- **Reset** (`rs_n`=0, asynchronous, including mid-sweep): state IDLE, `pos`=0, `dir_up`=1, `step`=0, `busy`=0, `done`=0, `cycle_cnt`=0, dwell timer=0, latched inputs=0.
  - Consequently `at_top`=0 and `at_bottom`=1.

## Timing
- `start` sampled at edge t; `busy`=1 from t.
- First `pos` change at edge t+`dwell`+1; subsequent steps every `dwell`+1 cycles.
- `step` is registered: it is high exactly in the cycle following the edge that updated `pos`.
- `at_top`/`at_bottom` are decoded from registered `pos`, with no extra latency.
- Final step to 0: `busy` falls and `done` pulses in the same cycle that `pos` becomes 0 and `step`=1.
- `abort` at edge a: `busy`=0 and `pos`=0 from edge a.
- A new `start` is accepted at the first edge with `busy`=0; the cycle in which `done`=1 qualifies.

## Structure
- Package `sweep_pkg` holds:
  - the state enum (IDLE/UP/DOWN);
  - the default parameter constants.
- One sub-module is natural: `sweep_dwell_timer`.
  - Loadable down-counter with width `DWELL_W`.
  - Ports: load, load value, enable, and a zero flag.
- Position, direction, cycle count and FSM stay in `sweep_sequencer`.

## Test plan
- Reset mid-sweep, `MAX_POS`=4, `dwell`=2, asserting `rs_n`=0 during DOWN: all outputs reach reset values immediately (`pos`=0, `busy`=0, `at_bottom`=1, `cycle_cnt`=0) without a clock edge.
- **Single triangle**
  - Setup: `MAX_POS`=4, `dwell`=0, `n_cycles`=1, start pulse at edge 0.
  - Expected: `pos` 1,2,3,4,3,2,1,0 on edges 1–8; `step` high 8 cycles; `at_top` in the cycle `pos`=4; `done`=1 and `busy`=0 at edge 8; `cycle_cnt`=1.
- **Dwell**
  - Setup: `dwell`=3, `n_cycles`=2.
  - Expected: steps exactly 4 cycles apart; 16 steps total; `done` after 64 cycles; `cycle_cnt`=2.
- **Continuous wrap**
  - Setup: `n_cycles`=0, `CYC_W`=2, `dwell`=0, run 5 triangles.
  - Expected: `cycle_cnt` 1,2,3,0,1; `done` never asserted; `busy` stays 1.
- **Abort at top**
  - Setup: `abort` in the cycle `pos`=4.
  - Expected: next edge `pos`=0, `busy`=0, no `done`; a `start` at the same edge as the abort in IDLE is ignored.
- **Start while busy**
  - Setup: a second `start` mid-sweep with different `dwell`/`n_cycles` values.
  - Expected: sequence unchanged from the original; the new values are used only after the next start from IDLE.
